// File: rtl/data_mem_lsu_if.sv
// Core/RAM-facing bundle of the load/store unit.
// The slave modport is the LSU itself; the master modport is the environment
// around it (core MEM stage on the request/response side, data RAM on the
// mem_* side).
interface data_mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  // Core request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  // Core response
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic [1:0]            resp_cause;
  // Data RAM port
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_cause, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_cause, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_lsu.sv
// RV32 load/store unit in front of a byte-enabled, synchronous-read data RAM.
// One request in flight: IDLE -> ACCESS -> (DATA) -> RESP, or straight to
// RESP when the request is rejected. Every RAM-side and response output is a
// flop, so nothing combinational from the core reaches the RAM.
module data_mem_lsu #(
  parameter int DEPTH      = 15,
  parameter int ADDR_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_e;

  typedef enum logic [1:0] {
    CAUSE_OK       = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_FAULT    = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } cause_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  cause_e                resp_cause_q, resp_cause_d;

  logic       req_illegal, req_misaligned, req_fault;
  cause_e     req_cause;
  logic [1:0] req_off;
  logic [3:0] req_be;
  logic [31:0] req_lanes;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign req_off = bus.req_addr[1:0];

  // Decode the incoming request: error cause, byte enables, lane-replicated data.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a value on
    // every path (here and in the next-state block via defaults first);
    // otherwise synthesis infers a latch.
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_lanes      = bus.req_wdata;

    if (bus.req_we) req_illegal = (bus.req_funct3 >= 3'b011);
    else            req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

    case (bus.req_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_off;
        req_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = req_off[0];
        req_be         = 4'b0011 << req_off;
        req_lanes      = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   req_misaligned = (req_off != 2'b00);
      default: req_misaligned = 1'b0;
    endcase

    // Anything beyond the 2^(DEPTH+2)-byte window has no backing RAM.
    req_fault = (bus.req_addr >> (DEPTH + 2)) != '0;

    if (req_illegal)         req_cause = CAUSE_ILLEGAL;
    else if (req_misaligned) req_cause = CAUSE_MISALIGN;
    else if (req_fault)      req_cause = CAUSE_FAULT;
    else                     req_cause = CAUSE_OK;
  end

  // Pick the addressed lane out of the RAM word and extend it to 32 bits.
  always_comb begin
    load_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'h0, load_byte};
      3'b101:  load_ext = {16'h0, load_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic of the request FSM.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_we_d     = 4'b0000;  // write strobes live for exactly the ACCESS cycle
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_cause_d = resp_cause_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d         = bus.req_we;
          funct3_d     = bus.req_funct3;
          addr_d       = bus.req_addr;
          wdata_d      = req_lanes;
          resp_rdata_d = '0;
          resp_cause_d = req_cause;
          if (req_cause != CAUSE_OK) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d  = ACCESS;
            mem_we_d = bus.req_we ? req_be : 4'b0000;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        resp_rdata_d = load_ext;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset also kills an in-flight write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_we_q     <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_cause_q <= CAUSE_OK;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_cause = resp_cause_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store unit that acts as the initiator toward the byte-enabled, synchronous-read data RAM (word-indexed, 4 byte columns, 1-cycle registered read).
- Accepts one RV32 load/store request at a time from the core over a valid/ready handshake.
- Generates the RAM byte enables and lane-replicated store data, then extracts and sign/zero-extends load data.
- Returns a response with an error cause; sits between the core MEM stage and the data RAM.

Parameters:
- DEPTH, 15, RAM word-address bits; addressable range is 2^(DEPTH+2) bytes.
- ADDR_WIDTH, 32, core byte-address width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_cause  output  2  0 ok, 1 misaligned, 2 access fault, 3 illegal funct3
- mem_we  output  4  RAM byte write enables
- mem_addr  output  ADDR_WIDTH  RAM byte address, word-aligned ({addr[ADDR_WIDTH-1:2],2'b00})
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, valid one cycle after the address is presented

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0; resp_rdata=0; resp_cause=0; mem_we=0.
  - Captured addr/funct3/we/wdata registers cleared, so mem_addr=0 and mem_wdata=0.
- State machine: IDLE, ACCESS, DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: capture request and compute cause.
  - Cause priority: illegal > misaligned > fault.
    - Illegal: load funct3 in {011,110,111}, or store funct3 >= 011.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
    - Fault: any addr bit at position DEPTH+2 or above is set.
  - cause!=0 -> RESP with resp_rdata=0. No RAM access occurs and mem_we stays 0.
  - Otherwise -> ACCESS.
- ACCESS (one cycle):
  - mem_addr from captured addr.
  - Store enables: mem_we = SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111, where off=addr[1:0]. Loads drive mem_we=0.
  - mem_wdata: SB = byte replicated x4; SH = halfword replicated x2; SW = unchanged.
  - Next state: store -> RESP (resp_cause=0, resp_rdata=0); load -> DATA.
- DATA (one cycle):
  - mem_rdata is valid.
  - Select byte at lane off, or halfword at lane off[1].
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register the result into resp_rdata, then -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_cause held stable until resp_ready.
  - On resp_ready -> IDLE and resp_valid drops the next cycle.
  - No new request is accepted in the same cycle.
- mem_we is nonzero only in ACCESS. mem_addr and mem_wdata hold their captured values outside ACCESS.
- Latency from accept cycle T:
  - load resp_valid at T+3
  - store resp_valid at T+2
  - error resp_valid at T+1
- Reset mid-operation: mem_we deasserts asynchronously with reset and the in-flight response is discarded. A write is committed only if a clock edge occurred during ACCESS before reset.
- req_valid outside IDLE is ignored (req_ready=0). The core holds its request stable until accepted.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF accepted at T -> mem_we=1111 at T+1, resp_valid T+2 cause 0. Then LW 0x10 -> resp_rdata 0xDEADBEEF at T+3.
- SB addr 0x13, wdata 0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5. Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
- SH addr 0x12, wdata 0x8001 -> mem_we=1100. Then LH 0x12 -> 0xFFFF8001; LHU -> 0x00008001; LW 0x10 -> 0x8001BEEF.
- LW 0x11 -> resp_cause=1 at T+1, mem_we never nonzero, resp_rdata=0. LH 0x20000 (DEPTH=15) -> cause 2. Load funct3=011 with misaligned addr -> cause 3.
- Hold resp_ready=0 for 3 cycles after resp_valid -> resp_rdata/resp_cause stable, req_ready=0, new req_valid ignored. Release -> IDLE next cycle.
- Assert rst_n=0 during ACCESS of SW 0x20 -> mem_we=0 immediately, resp_valid=0. A subsequent LW 0x20 returns the old contents.
